// File: rtl/rst_seq_sys_pkg.sv
// Shared types for the clk_sys reset sequencer: FSM states and reset-cause codes.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_PERIPH = 2'd1,
        ST_RUN    = 2'd2
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_EXT = 2'b01,
        CAUSE_SW  = 2'b10
    } rst_cause_e;

endpackage

// File: rtl/rst_seq_sys_if.sv
// Control/status bundle between the reset sequencer (slave) and its requester/observer (master).
interface rst_seq_sys_if;
    logic       sw_rst_req;
    logic       rst_periph_n;
    logic       rst_core_n;
    logic       rst_done;
    logic [1:0] rst_cause;

    modport master (output sw_rst_req,
                    input  rst_periph_n, rst_core_n, rst_done, rst_cause);
    modport slave  (input  sw_rst_req,
                    output rst_periph_n, rst_core_n, rst_done, rst_cause);
endinterface

// File: rtl/rst_seq_sys_sync.sv
// Async-assert / sync-deassert reset synchronizer; domain-agnostic so it can be reused elsewhere.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign o_rst_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_sys.sv
// clk_sys reset sequencer: releases peripheral then core reset in counted order,
// restarts on a software request and records the cause of the last reset.
module rst_seq_sys
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CORE_DELAY  = 4,
    parameter int CNT_W       = $clog2((HOLD_CYCLES > CORE_DELAY ? HOLD_CYCLES : CORE_DELAY) + 1)
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    rst_seq_sys_if.slave  bus
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("rst_seq_sys: SYNC_STAGES must be >= 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("rst_seq_sys: HOLD_CYCLES must be >= 1");
        end
        if (CORE_DELAY < 1) begin : g_bad_core
            $error("rst_seq_sys: CORE_DELAY must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);

    logic             w_rst_int_n;
    rst_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_periph_n, w_periph_nxt;
    logic             r_core_n, w_core_nxt;
    logic             r_done, w_done_nxt;
    rst_cause_e       r_cause, w_cause_nxt;

    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (clk_sys),
        .i_rst_n (rst_sys_n),
        .o_rst_n (w_rst_int_n)
    );

    // rst_sys_n low clears the synchronizer, which clears everything here in the same instant.
    always_ff @(posedge clk_sys or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_periph_n <= 1'b0;
            r_core_n   <= 1'b0;
            r_done     <= 1'b0;
            r_cause    <= CAUSE_EXT;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_periph_n <= w_periph_nxt;
            r_core_n   <= w_core_nxt;
            r_done     <= w_done_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_periph_nxt = r_periph_n;
        w_core_nxt   = r_core_n;
        w_done_nxt   = r_done;
        w_cause_nxt  = r_cause;
        // A software request outranks the PERIPH->RUN step; in HOLD it is ignored,
        // so a held request cannot stretch the sequence.
        if (bus.sw_rst_req && (r_state == ST_PERIPH || r_state == ST_RUN)) begin
            w_state_nxt  = ST_HOLD;
            w_cnt_nxt    = '0;
            w_periph_nxt = 1'b0;
            w_core_nxt   = 1'b0;
            w_done_nxt   = 1'b0;
            w_cause_nxt  = CAUSE_SW;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nxt  = ST_PERIPH;
                        w_cnt_nxt    = '0;
                        w_periph_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_PERIPH: begin
                    if (r_cnt == CORE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_core_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: ;
                default: begin
                    w_state_nxt  = ST_HOLD;
                    w_cnt_nxt    = '0;
                    w_periph_nxt = 1'b0;
                    w_core_nxt   = 1'b0;
                    w_done_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_periph_n = r_periph_n;
    assign bus.rst_core_n   = r_core_n;
    assign bus.rst_done     = r_done;
    assign bus.rst_cause    = r_cause;

endmodule

// File: tb/tb_rst_seq_sys.sv
// Directed bench for rst_seq_sys: default instance plus a SYNC=3/HOLD=1/CORE=1 instance.
module tb_rst_seq_sys;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    int   edge_n    = 0;
    int   checks    = 0;
    int   errors    = 0;

    rst_seq_sys_if u_if ();
    rst_seq_sys_if u_if_p ();

    rst_seq_sys u_dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (u_if.slave)
    );

    rst_seq_sys #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .CORE_DELAY(1)) u_dut_p (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (u_if_p.slave)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance to just after edge n (numbered from the last release).
    task automatic goto(input int n);
        while (edge_n < n) begin
            @(posedge clk_sys);
            edge_n++;
        end
        #1;
    endtask

    task automatic release_rst();
        rst_sys_n = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        edge_n    = 0;
    endtask

    task automatic test_reset();
        u_if.sw_rst_req   = 1'b0;
        u_if_p.sw_rst_req = 1'b0;
        rst_sys_n = 1'b0;
        #12;
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_vals: got %b want 00001", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
        checks++;
        if ({u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done, u_if_p.rst_cause} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_vals_p: got %b want 00001", {u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done, u_if_p.rst_cause});
        end
    endtask

    task automatic test_power_on();
        release_rst();
        goto(17);
        checks++;
        if (u_if.rst_periph_n !== 1'b0) begin errors++; $display("FAIL po_periph_e17: got %b want 0", u_if.rst_periph_n); end
        goto(18);
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done} !== 3'b100) begin
            errors++; $display("FAIL po_e18: got %b want 100", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done});
        end
        goto(21);
        checks++;
        if ({u_if.rst_core_n, u_if.rst_done} !== 2'b00) begin
            errors++; $display("FAIL po_core_e21: got %b want 00", {u_if.rst_core_n, u_if.rst_done});
        end
        goto(22);
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 5'b11101) begin
            errors++; $display("FAIL po_e22: got %b want 11101", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
    endtask

    task automatic test_sw_run();
        goto(39);
        u_if.sw_rst_req = 1'b1;
        goto(40);
        u_if.sw_rst_req = 1'b0;
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 5'b00010) begin
            errors++; $display("FAIL sw_e40: got %b want 00010", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
        goto(55);
        checks++;
        if (u_if.rst_periph_n !== 1'b0) begin errors++; $display("FAIL sw_periph_e55: got %b want 0", u_if.rst_periph_n); end
        goto(56);
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n} !== 2'b10) begin
            errors++; $display("FAIL sw_e56: got %b want 10", {u_if.rst_periph_n, u_if.rst_core_n});
        end
        goto(59);
        checks++;
        if (u_if.rst_core_n !== 1'b0) begin errors++; $display("FAIL sw_core_e59: got %b want 0", u_if.rst_core_n); end
        goto(60);
        checks++;
        if ({u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 4'b1110) begin
            errors++; $display("FAIL sw_e60: got %b want 1110", {u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
    endtask

    task automatic test_async();
        release_rst();
        goto(20);
        checks++;
        if (u_if.rst_periph_n !== 1'b1) begin errors++; $display("FAIL async_pre: got %b want 1", u_if.rst_periph_n); end
        #2;
        rst_sys_n = 1'b0;
        #1;
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 5'b00001) begin
            errors++; $display("FAIL async_clear: got %b want 00001", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        edge_n    = 0;
        goto(17);
        checks++;
        if (u_if.rst_periph_n !== 1'b0) begin errors++; $display("FAIL async_periph_e17: got %b want 0", u_if.rst_periph_n); end
        goto(18);
        checks++;
        if (u_if.rst_periph_n !== 1'b1) begin errors++; $display("FAIL async_periph_e18: got %b want 1", u_if.rst_periph_n); end
        goto(22);
        checks++;
        if ({u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 4'b1101) begin
            errors++; $display("FAIL async_e22: got %b want 1101", {u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
    endtask

    task automatic test_hold_ignored();
        release_rst();
        goto(9);
        u_if.sw_rst_req = 1'b1;
        goto(10);
        u_if.sw_rst_req = 1'b0;
        goto(17);
        checks++;
        if (u_if.rst_periph_n !== 1'b0) begin errors++; $display("FAIL hold_periph_e17: got %b want 0", u_if.rst_periph_n); end
        goto(18);
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_cause} !== 3'b101) begin
            errors++; $display("FAIL hold_e18: got %b want 101", {u_if.rst_periph_n, u_if.rst_cause});
        end
        goto(22);
        checks++;
        if ({u_if.rst_core_n, u_if.rst_done} !== 2'b11) begin
            errors++; $display("FAIL hold_e22: got %b want 11", {u_if.rst_core_n, u_if.rst_done});
        end
    endtask

    task automatic test_coincident();
        release_rst();
        goto(21);
        u_if.sw_rst_req = 1'b1;
        goto(22);
        u_if.sw_rst_req = 1'b0;
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause} !== 5'b00010) begin
            errors++; $display("FAIL coin_e22: got %b want 00010", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_done, u_if.rst_cause});
        end
        goto(37);
        checks++;
        if (u_if.rst_periph_n !== 1'b0) begin errors++; $display("FAIL coin_periph_e37: got %b want 0", u_if.rst_periph_n); end
        goto(38);
        checks++;
        if (u_if.rst_periph_n !== 1'b1) begin errors++; $display("FAIL coin_periph_e38: got %b want 1", u_if.rst_periph_n); end
        goto(41);
        checks++;
        if (u_if.rst_core_n !== 1'b0) begin errors++; $display("FAIL coin_core_e41: got %b want 0", u_if.rst_core_n); end
        goto(42);
        checks++;
        if (u_if.rst_core_n !== 1'b1) begin errors++; $display("FAIL coin_core_e42: got %b want 1", u_if.rst_core_n); end
    endtask

    // Request held for edges 50..53: only edge 50 restarts, so periph at 66, core at 70.
    task automatic test_back_to_back();
        goto(49);
        u_if.sw_rst_req = 1'b1;
        goto(53);
        u_if.sw_rst_req = 1'b0;
        checks++;
        if ({u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_cause} !== 4'b0010) begin
            errors++; $display("FAIL held_e53: got %b want 0010", {u_if.rst_periph_n, u_if.rst_core_n, u_if.rst_cause});
        end
        goto(65);
        checks++;
        if (u_if.rst_periph_n !== 1'b0) begin errors++; $display("FAIL held_periph_e65: got %b want 0", u_if.rst_periph_n); end
        goto(66);
        checks++;
        if (u_if.rst_periph_n !== 1'b1) begin errors++; $display("FAIL held_periph_e66: got %b want 1", u_if.rst_periph_n); end
        goto(69);
        checks++;
        if (u_if.rst_core_n !== 1'b0) begin errors++; $display("FAIL held_core_e69: got %b want 0", u_if.rst_core_n); end
        goto(70);
        checks++;
        if ({u_if.rst_core_n, u_if.rst_done} !== 2'b11) begin
            errors++; $display("FAIL held_e70: got %b want 11", {u_if.rst_core_n, u_if.rst_done});
        end
    endtask

    task automatic test_param();
        release_rst();
        goto(3);
        checks++;
        if ({u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done} !== 3'b000) begin
            errors++; $display("FAIL par_e3: got %b want 000", {u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done});
        end
        goto(4);
        checks++;
        if ({u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done} !== 3'b100) begin
            errors++; $display("FAIL par_e4: got %b want 100", {u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done});
        end
        goto(5);
        checks++;
        if ({u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done, u_if_p.rst_cause} !== 5'b11101) begin
            errors++; $display("FAIL par_e5: got %b want 11101", {u_if_p.rst_periph_n, u_if_p.rst_core_n, u_if_p.rst_done, u_if_p.rst_cause});
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_sw_run();
        test_async();
        test_hold_ignored();
        test_coincident();
        test_back_to_back();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
